// File: rtl/prog_clk_divider.sv
// ---------------------------------------------------------------------------
// prog_clk_divider
// Runtime-reconfigurable clock / strobe generator. A counter runs 0..div_a
// (a period of div_a+1 cycles) and drives one of three output shapes:
//   mode 0/3 : toggle on every wrap (divided clock, 50% duty)
//   mode 1   : one-cycle pulse on every wrap
//   mode 2   : high for high_a cycles, then low for the rest of the period
// New settings are captured into a shadow on LOAD and only become active at
// a period boundary (or immediately on an idle edge while EN is low), so the
// output never shows a truncated or glitched period.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous, active-high reset
//   EN       in   run enable; low stops and clears counter/outputs
//   DIV      in   requested divisor (period = DIV+1 cycles)
//   HIGH     in   requested high-count for duty mode
//   MODE     in   requested output mode
//   LOAD     in   one-cycle capture strobe for DIV/HIGH/MODE
//   OUT_CLK  out  divided clock / strobe / PWM (registered)
//   TICK     out  one-cycle strobe per counter period (registered)
//   CFG_PEND out  shadow configuration waiting to be applied (registered)
// ---------------------------------------------------------------------------
module prog_clk_divider #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] DIV_RST  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] HIGH_RST = {WIDTH{1'b0}},
    parameter logic [1:0]       MODE_RST = 2'd0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic [WIDTH-1:0] HIGH,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    output logic             OUT_CLK,
    output logic             TICK,
    output logic             CFG_PEND
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // active configuration
    logic [WIDTH-1:0] div_a_r;
    logic [WIDTH-1:0] high_a_r;
    logic [1:0]       mode_a_r;
    // shadow configuration
    logic [WIDTH-1:0] div_sh_r;
    logic [WIDTH-1:0] high_sh_r;
    logic [1:0]       mode_sh_r;
    logic             pend_r;

    logic [WIDTH-1:0] cnt_r;
    logic             out_r;
    logic             tick_r;

    logic             wrap_s;
    logic             apply_s;
    logic [WIDTH-1:0] cnt_next_s;
    logic [WIDTH-1:0] eff_high_s;
    logic [1:0]       eff_mode_s;
    logic             out_next_s;

    // Period boundary detection, apply decision and next output value.
    always_comb begin
        wrap_s     = (cnt_r == div_a_r);
        cnt_next_s = wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);

        // While running, a pending config lands on the wrap edge. While
        // stopped, it lands on any edge that is not itself re-loading.
        if (EN) begin
            apply_s = pend_r & wrap_s;
        end else begin
            apply_s = pend_r & ~LOAD;
        end

        // The edge that applies a new config already shapes the output
        // with the new mode/high so the first new period is complete.
        if (apply_s) begin
            eff_high_s = high_sh_r;
            eff_mode_s = mode_sh_r;
        end else begin
            eff_high_s = high_a_r;
            eff_mode_s = mode_a_r;
        end

        if (!EN) begin
            out_next_s = 1'b0;
        end else begin
            case (eff_mode_s)
                2'd1:    out_next_s = wrap_s;
                2'd2:    out_next_s = (cnt_next_s < eff_high_s);
                default: out_next_s = wrap_s ? ~out_r : out_r;
            endcase
        end
    end

    // Counter and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r  <= CNT_ZERO;
            out_r  <= 1'b0;
            tick_r <= 1'b0;
        end else if (EN) begin
            cnt_r  <= cnt_next_s;
            out_r  <= out_next_s;
            tick_r <= wrap_s;
        end else begin
            cnt_r  <= CNT_ZERO;
            out_r  <= 1'b0;
            tick_r <= 1'b0;
        end
    end

    // Shadow capture, active update and pending flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_a_r   <= DIV_RST;
            high_a_r  <= HIGH_RST;
            mode_a_r  <= MODE_RST;
            div_sh_r  <= DIV_RST;
            high_sh_r <= HIGH_RST;
            mode_sh_r <= MODE_RST;
            pend_r    <= 1'b0;
        end else begin
            // Active takes the shadow as it was before this edge's capture.
            if (apply_s) begin
                div_a_r  <= div_sh_r;
                high_a_r <= high_sh_r;
                mode_a_r <= mode_sh_r;
            end else begin
                div_a_r  <= div_a_r;
                high_a_r <= high_a_r;
                mode_a_r <= mode_a_r;
            end

            if (LOAD) begin
                div_sh_r  <= DIV;
                high_sh_r <= HIGH;
                mode_sh_r <= MODE;
                pend_r    <= 1'b1;
            end else if (apply_s) begin
                pend_r    <= 1'b0;
            end else begin
                pend_r    <= pend_r;
            end
        end
    end

    assign OUT_CLK  = out_r;
    assign TICK     = tick_r;
    assign CFG_PEND = pend_r;

endmodule

// File: tb/tb_prog_clk_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_clk_divider
// Self-checking bench for prog_clk_divider (WIDTH=8, DIV_RST=3, mode toggle).
// A behavioural model tracks the period position and active/shadow configs
// from the documented rules; directed scenarios add explicit expectations.
// ---------------------------------------------------------------------------
module tb_prog_clk_divider;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic         EN;
    logic [W-1:0] DIV;
    logic [W-1:0] HIGH;
    logic [1:0]   MODE;
    logic         LOAD;
    logic         OUT_CLK;
    logic         TICK;
    logic         CFG_PEND;

    int cmp_count;
    int fail_count;

    // reference model state
    int m_pos;
    int m_div, m_high, m_mode;
    int s_div, s_high, s_mode;
    bit m_pend, m_out, m_tick;

    prog_clk_divider #(
        .WIDTH   (W),
        .DIV_RST (8'd3),
        .HIGH_RST(8'd0),
        .MODE_RST(2'd0)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .DIV     (DIV),
        .HIGH    (HIGH),
        .MODE    (MODE),
        .LOAD    (LOAD),
        .OUT_CLK (OUT_CLK),
        .TICK    (TICK),
        .CFG_PEND(CFG_PEND)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        m_pos  = 0;
        m_div  = 3; m_high = 0; m_mode = 0;
        s_div  = 3; s_high = 0; s_mode = 0;
        m_pend = 1'b0; m_out = 1'b0; m_tick = 1'b0;
    endtask

    // One clock edge of the documented behaviour, using inputs as seen at the edge.
    task automatic model_edge();
        bit at_end;
        if (!EN) begin
            if (m_pend && !LOAD) begin
                m_div = s_div; m_high = s_high; m_mode = s_mode; m_pend = 1'b0;
            end
            if (LOAD) begin
                s_div = int'(DIV); s_high = int'(HIGH); s_mode = int'(MODE); m_pend = 1'b1;
            end
            m_pos = 0; m_out = 1'b0; m_tick = 1'b0;
        end else begin
            at_end = (m_pos == m_div);
            if (at_end && m_pend) begin
                m_div = s_div; m_high = s_high; m_mode = s_mode; m_pend = 1'b0;
            end
            if (LOAD) begin
                s_div = int'(DIV); s_high = int'(HIGH); s_mode = int'(MODE); m_pend = 1'b1;
            end
            m_pos  = at_end ? 0 : m_pos + 1;
            m_tick = at_end;
            if (m_mode == 1)      m_out = at_end;
            else if (m_mode == 2) m_out = (m_pos < m_high);
            else if (at_end)      m_out = !m_out;
        end
    endtask

    // Advance one clock edge, update the model, settle past the edge.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_load(input int d, input int h, input int m);
        DIV  = W'(d);
        HIGH = W'(h);
        MODE = 2'(m);
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0;
        DIV = 8'd0; HIGH = 8'd0; MODE = 2'd0;
        model_reset();
        #12;
        cmp_count++;
        if ({OUT_CLK, TICK, CFG_PEND} !== 3'b000) begin
            fail_count++;
            $display("FAIL reset_state: got out=%0b tick=%0b pend=%0b, want 000", OUT_CLK, TICK, CFG_PEND);
        end
        RST = 1'b0;
    endtask

    task automatic test_toggle_default();
        bit exp_out, exp_tick;
        EN = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_out  = ((k / 4) % 2) == 1;
            exp_tick = (k % 4) == 0;
            cmp_count++;
            if (OUT_CLK !== exp_out || TICK !== exp_tick || CFG_PEND !== 1'b0) begin
                fail_count++;
                $display("FAIL toggle_default edge %0d: got out=%0b tick=%0b pend=%0b, want %0b %0b 0",
                         k, OUT_CLK, TICK, CFG_PEND, exp_out, exp_tick);
            end
        end
    endtask

    task automatic run_duty(input int high, input string name);
        bit exp_out;
        EN = 1'b0;
        do_load(4, high, 2);
        step();
        cmp_count++;
        if (CFG_PEND !== 1'b0) begin
            fail_count++;
            $display("FAIL %s apply_idle: got pend=%0b, want 0", name, CFG_PEND);
        end
        EN = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            exp_out = ((k % 5) < high);
            cmp_count++;
            if (OUT_CLK !== exp_out || OUT_CLK !== m_out) begin
                fail_count++;
                $display("FAIL %s edge %0d: got out=%0b, want %0b (model %0b)", name, k, OUT_CLK, exp_out, m_out);
            end
        end
    endtask

    task automatic test_duty();
        run_duty(2, "duty_h2");
        run_duty(0, "duty_h0");
        run_duty(7, "duty_h7");
    endtask

    task automatic test_reload_pulse();
        bit exp_out;
        EN = 1'b0;
        do_load(9, 0, 1);
        step();
        EN = 1'b1;
        repeat (3) step();
        do_load(2, 0, 1);
        for (int j = 1; j <= 6; j++) begin
            step();
            cmp_count++;
            if (CFG_PEND !== (j < 6) || OUT_CLK !== (j == 6)) begin
                fail_count++;
                $display("FAIL reload_pulse old_period %0d: got pend=%0b out=%0b, want %0b %0b",
                         j, CFG_PEND, OUT_CLK, (j < 6), (j == 6));
            end
        end
        for (int j = 1; j <= 9; j++) begin
            step();
            exp_out = (j % 3) == 0;
            cmp_count++;
            if (OUT_CLK !== exp_out || TICK !== exp_out || CFG_PEND !== 1'b0) begin
                fail_count++;
                $display("FAIL reload_pulse new_period %0d: got out=%0b tick=%0b pend=%0b, want %0b %0b 0",
                         j, OUT_CLK, TICK, CFG_PEND, exp_out, exp_out);
            end
        end
    endtask

    task automatic test_en_drop();
        EN = 1'b0;
        do_load(3, 0, 0);
        step();
        EN = 1'b1;
        repeat (5) step();
        cmp_count++;
        if (OUT_CLK !== 1'b1) begin
            fail_count++;
            $display("FAIL en_drop precondition: got out=%0b, want 1", OUT_CLK);
        end
        EN = 1'b0;
        step();
        cmp_count++;
        if (OUT_CLK !== 1'b0 || TICK !== 1'b0) begin
            fail_count++;
            $display("FAIL en_drop stop: got out=%0b tick=%0b, want 0 0", OUT_CLK, TICK);
        end
        EN = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            cmp_count++;
            if (OUT_CLK !== (k == 4) || TICK !== (k == 4)) begin
                fail_count++;
                $display("FAIL en_drop restart edge %0d: got out=%0b tick=%0b, want %0b %0b",
                         k, OUT_CLK, TICK, (k == 4), (k == 4));
            end
        end
    endtask

    task automatic test_load_on_wrap();
        int guard;
        guard = 0;
        while (m_pos != m_div && guard < 20) begin
            step();
            guard++;
        end
        DIV = 8'd5; HIGH = 8'd0; MODE = 2'd1; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        cmp_count++;
        if (CFG_PEND !== 1'b1 || TICK !== 1'b1) begin
            fail_count++;
            $display("FAIL load_on_wrap capture: got pend=%0b tick=%0b, want 1 1", CFG_PEND, TICK);
        end
        for (int k = 1; k <= 14; k++) begin
            step();
            cmp_count++;
            if ({OUT_CLK, TICK, CFG_PEND} !== {m_out, m_tick, m_pend}) begin
                fail_count++;
                $display("FAIL load_on_wrap run %0d: got %b%b%b, want %b%b%b",
                         k, OUT_CLK, TICK, CFG_PEND, m_out, m_tick, m_pend);
            end
        end
        do_load(1, 0, 1);
        do_load(2, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            step();
            cmp_count++;
            if ({OUT_CLK, TICK, CFG_PEND} !== {m_out, m_tick, m_pend}) begin
                fail_count++;
                $display("FAIL double_load run %0d: got %b%b%b, want %b%b%b",
                         k, OUT_CLK, TICK, CFG_PEND, m_out, m_tick, m_pend);
            end
        end
    endtask

    task automatic test_async_reset();
        EN = 1'b1;
        do_load(6, 2, 2);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        cmp_count++;
        if ({OUT_CLK, TICK, CFG_PEND} !== 3'b000) begin
            fail_count++;
            $display("FAIL async_reset: got out=%0b tick=%0b pend=%0b, want 000", OUT_CLK, TICK, CFG_PEND);
        end
        #2;
        RST = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            cmp_count++;
            if (OUT_CLK !== (((k / 4) % 2) == 1) || TICK !== ((k % 4) == 0) || CFG_PEND !== 1'b0) begin
                fail_count++;
                $display("FAIL after_reset_defaults edge %0d: got out=%0b tick=%0b pend=%0b",
                         k, OUT_CLK, TICK, CFG_PEND);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            EN   = ($urandom_range(0, 11) != 0);
            LOAD = ($urandom_range(0, 7) == 0);
            DIV  = W'($urandom_range(0, 6));
            HIGH = W'($urandom_range(0, 8));
            MODE = 2'($urandom_range(0, 3));
            step();
            cmp_count++;
            if ({OUT_CLK, TICK, CFG_PEND} !== {m_out, m_tick, m_pend}) begin
                fail_count++;
                $display("FAIL random cycle %0d: got out=%0b tick=%0b pend=%0b, want %0b %0b %0b",
                         k, OUT_CLK, TICK, CFG_PEND, m_out, m_tick, m_pend);
            end
        end
        LOAD = 1'b0;
    endtask

    initial begin
        cmp_count  = 0;
        fail_count = 0;
        test_reset();
        test_toggle_default();
        test_duty();
        test_reload_pulse();
        test_en_drop();
        test_load_on_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
